// File: rtl/icap_xfer_ctrl.sv
// ICAPE2 transfer controller: a write FIFO streams bitstream words into the ICAP, and readback
// words flow into a read FIFO, with reads issued only while the FIFO can absorb them.
module icap_xfer_ctrl #(
    parameter int BUS_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int RD_LATENCY = 3,
    parameter int BIT_SWAP   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic                 rd_start,
    input  logic [15:0]          rd_words,
    output logic [BUS_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           status,
    output logic                 icap_csib,
    output logic                 icap_rdwrb,
    output logic [BUS_WIDTH-1:0] icap_i,
    input  logic [BUS_WIDTH-1:0] icap_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_TURN_RD = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_TURN_WR = 3'd5;

    logic [2:0]           state_q, state_d;
    logic                 icap_csib_q, icap_csib_d;
    logic                 icap_rdwrb_q, icap_rdwrb_d;
    logic [BUS_WIDTH-1:0] icap_i_q, icap_i_d;
    logic [3:0]           status_q, status_d;
    logic [15:0]          words_q, words_d;
    logic [15:0]          issued_q, issued_d;
    logic [PW-1:0]        inflight_q, inflight_d;
    logic [RD_LATENCY-1:0] lat_sr_q, lat_sr_d;

    logic [BUS_WIDTH-1:0] wf_mem [FIFO_DEPTH];
    logic [PW-1:0]        wf_wptr_q, wf_rptr_q;
    logic [BUS_WIDTH-1:0] rf_mem [FIFO_DEPTH];
    logic [PW-1:0]        rf_wptr_q, rf_rptr_q;

    logic                 wf_empty, wf_full, wf_push, wf_pop;
    logic                 rf_empty, rf_push, rf_pop;
    logic [PW-1:0]        rf_count, rf_free;
    logic                 rd_on_bus, issue;
    logic [BUS_WIDTH-1:0] wf_rdata, wf_rdata_sw, icap_o_sw;

    // Optional bit reversal inside every byte, applied to both ICAP directions.
    for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_swap
        localparam int SRC = (BIT_SWAP != 0) ? ((gi / 8) * 8 + 7 - (gi % 8)) : gi;
        assign wf_rdata_sw[gi] = wf_rdata[SRC];
        assign icap_o_sw[gi]   = icap_o[SRC];
    end

    // Each issued read walks down this pipe and lands in the read FIFO as it falls out.
    assign lat_sr_d[0] = rd_on_bus;
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_lat
        assign lat_sr_d[gi] = lat_sr_q[gi-1];
    end

    assign wf_empty = (wf_wptr_q == wf_rptr_q);
    assign wf_full  = (wf_wptr_q[AW] != wf_rptr_q[AW]) && (wf_wptr_q[AW-1:0] == wf_rptr_q[AW-1:0]);
    assign wr_ready = !rst && !wf_full;
    assign wf_push  = wr_valid && wr_ready;
    assign wf_pop   = (state_q == S_WRITE) && !wf_empty;
    assign wf_rdata = wf_mem[wf_rptr_q[AW-1:0]];

    assign rf_empty = (rf_wptr_q == rf_rptr_q);
    assign rf_count = rf_wptr_q - rf_rptr_q;
    assign rf_free  = PW'(FIFO_DEPTH) - rf_count;
    assign rf_push  = lat_sr_q[RD_LATENCY-1];
    assign rd_valid = !rst && !rf_empty;
    assign rf_pop   = rd_valid && rd_ready;
    assign rd_data  = rf_mem[rf_rptr_q[AW-1:0]];

    assign rd_on_bus  = !icap_csib_q && icap_rdwrb_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_TURN_WR);
    assign status     = status_q;
    assign icap_csib  = icap_csib_q;
    assign icap_rdwrb = icap_rdwrb_q;
    assign icap_i     = icap_i_q;

    always_ff @(posedge clk) begin
        if (wf_push) wf_mem[wf_wptr_q[AW-1:0]] <= wr_data;
        if (rf_push) rf_mem[rf_wptr_q[AW-1:0]] <= icap_o_sw;
    end

    always_comb begin
        state_d      = state_q;
        icap_csib_d  = 1'b1;
        icap_rdwrb_d = icap_rdwrb_q;
        icap_i_d     = icap_i_q;
        words_d      = words_q;
        issued_d     = issued_q;
        issue        = 1'b0;
        status_d     = status_q;
        case (state_q)
            S_IDLE: begin
                if (icap_csib_q && icap_o_sw[1:0] == 2'b11) status_d = icap_o_sw[7:4];
                if (!wf_empty) begin
                    state_d = S_WRITE;
                end else if (rd_start && rd_words != 16'd0) begin
                    state_d      = S_TURN_RD;
                    icap_rdwrb_d = 1'b1;
                    words_d      = rd_words;
                    issued_d     = 16'd0;
                end
            end
            S_WRITE: begin
                if (!wf_empty) begin
                    icap_csib_d = 1'b0;
                    icap_i_d    = wf_rdata_sw;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN_RD, S_READ: begin
                state_d = S_READ;
                // Free space must cover every read still in the pipe, so a push can never overflow.
                if (issued_q != words_q && rf_free > inflight_q) begin
                    issue       = 1'b1;
                    icap_csib_d = 1'b0;
                    issued_d    = issued_q + 16'd1;
                end
                if (issued_d == words_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d      = S_TURN_WR;
                    icap_rdwrb_d = 1'b0;
                end
            end
            S_TURN_WR: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        inflight_d = inflight_q + PW'(issue) - PW'(rf_push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            icap_csib_q  <= 1'b1;
            icap_rdwrb_q <= 1'b0;
            icap_i_q     <= '0;
            status_q     <= 4'b1001;
            words_q      <= '0;
            issued_q     <= '0;
            inflight_q   <= '0;
            lat_sr_q     <= '0;
            wf_wptr_q    <= '0;
            wf_rptr_q    <= '0;
            rf_wptr_q    <= '0;
            rf_rptr_q    <= '0;
        end else begin
            state_q      <= state_d;
            icap_csib_q  <= icap_csib_d;
            icap_rdwrb_q <= icap_rdwrb_d;
            icap_i_q     <= icap_i_d;
            status_q     <= status_d;
            words_q      <= words_d;
            issued_q     <= issued_d;
            inflight_q   <= inflight_d;
            lat_sr_q     <= lat_sr_d;
            wf_wptr_q    <= wf_wptr_q + PW'(wf_push);
            wf_rptr_q    <= wf_rptr_q + PW'(wf_pop);
            rf_wptr_q    <= rf_wptr_q + PW'(rf_push);
            rf_rptr_q    <= rf_rptr_q + PW'(rf_pop);
        end
    end

endmodule
